dcache_rsp_arb: RTL and testbench
=================================

Name: dcache_rsp_arb

Overview:
- Merges NUM_INPUTS independent dcache response streams (e.g. dcache banks, shared memory) into one dcache response channel toward the LSU commit stage.
- Arbitration is round-robin. The source index is appended to the tag LSBs so downstream logic can identify the source.
- A 2-entry output elastic buffer registers the output and sustains 1 response/cycle.
- Input and output channels are flattened dcache response interfaces (valid/tmask/data/tag/ready).

Parameters:
- NUM_INPUTS, 2, number of response sources merged (>=1)
- NUM_REQS, 4, lanes per response (tmask/data width)
- WORD_SIZE, 4, bytes per lane word; lane width WORD_W = 8*WORD_SIZE
- TAG_IN_WIDTH, 8, per-input tag width
- SEL_W, derived, clog2(NUM_INPUTS), 0 when NUM_INPUTS=1
- TAG_OUT_WIDTH, derived, TAG_IN_WIDTH+SEL_W

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  NUM_INPUTS  per-source response valid
- in_tmask  in  NUM_INPUTS*NUM_REQS  per-source lane mask
- in_data  in  NUM_INPUTS*NUM_REQS*WORD_W  per-source lane data
- in_tag  in  NUM_INPUTS*TAG_IN_WIDTH  per-source tag
- in_ready  out  NUM_INPUTS  per-source accept
- out_valid  out  1  merged response valid
- out_tmask  out  NUM_REQS  merged lane mask
- out_data  out  NUM_REQS*WORD_W  merged lane data
- out_tag  out  TAG_OUT_WIDTH  {in_tag[src], src} (source index in LSBs)
- out_ready  in  1  downstream accept

Behaviour:
- Single clock domain. Reset is synchronous and active-low on reset_n; all state updates on the rising edge of clk.
- Reset values:
  - buffer count=0, so out_valid=0.
  - out_tmask/out_data/out_tag=0.
  - rr_ptr=0.
  - in_ready=0 while reset_n=0.
- Arbitration (combinational each cycle):
  - grant = first i with in_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_INPUTS.
  - No valid input means no grant.
- Acceptance:
  - in_ready[i] = grant[i] & (count<2) & reset_n.
  - in_ready is asserted to at most one source per cycle.
  - An un-granted source holds valid and payload stable (standard valid/ready).
- Pointer update:
  - On a handshake with source g, rr_ptr <= (g+1) mod NUM_INPUTS, wrapping at NUM_INPUTS-1 to 0.
  - rr_ptr is unchanged when there is no handshake.
  - Fairness: with all inputs continuously valid, each source is served once per NUM_INPUTS handshakes.
- Buffer: 2-entry FIFO (head/tail pointers, count 0..2).
  - push = any in handshake; pop = out_valid & out_ready.
  - Simultaneous push+pop: count unchanged, and entry order is preserved.
  - count=2: no grant is accepted (in_ready all 0), even if out_ready=1 that cycle. Ready does not combinationally depend on out_ready.
  - count=0 with push: out_valid=1 next cycle.
- Output:
  - out_valid = (count!=0); out_* come from the head entry.
  - Latency: handshake in cycle N gives out_valid in N+1, when the buffer was empty.
  - Throughput: 1/cycle sustained while out_ready=1.
  - out_* stays stable while out_valid & !out_ready.
- tmask=0 responses are forwarded unchanged. The block is payload-agnostic.
- NUM_INPUTS=1: pure 2-entry elastic buffer; out_tag=in_tag and rr_ptr is unused.
- Reset mid-operation: buffered entries are discarded, and count/rr_ptr/out_valid clear on the next edge with reset_n=0.
- Assertions:
  - onehot0(in_ready).
  - No push when count=2.
  - out_* stable during stall.

Decomposition:
- Shared package dcache_arb_pkg:
  - SEL_W/TAG_OUT_WIDTH computation function (clog2 with 1→0 rule).
  - Response-entry packed struct {tmask, data, tag}, parameterised through localparam widths in the instantiating module.
- One sub-module, rr_arbiter:
  - Parameter NUM_INPUTS.
  - Inputs: requests, advance strobe, grant index.
  - Outputs: one-hot grant and valid.
  - Owns rr_ptr.
- The 2-entry FIFO stays inline in dcache_rsp_arb.

Test Plan:
- Reset: hold reset_n=0 with in_valid=2'b11 for 3 cycles → in_ready=0, out_valid=0, out_tag=0. Release → first grant goes to source 0.
- Single source: in_valid=2'b10, tmask=4'b1011, tag=8'h5A, out_ready=1 → next cycle out_valid=1, out_tmask=4'b1011, out_tag=9'h0B5 ({8'h5A,1'b1}), data matches.
- Round-robin: both sources continuously valid for 6 handshakes, out_ready=1 → source order 0,1,0,1,0,1 (tag LSB alternates); one output per cycle after a 1-cycle fill.
- Backpressure: out_ready=0 with both valid → exactly 2 handshakes, then in_ready=0 and out_* stable. Raise out_ready → drains in order, one per cycle, with no loss or duplication.
- Simultaneous push/pop at count=1: valid source 1, out_ready=1 → count stays 1 and output order is preserved.
- Reset mid-stream: buffer full (count=2), pulse reset_n=0 for 1 cycle → out_valid=0 the next cycle and rr_ptr=0. The next grant with both valid goes to source 0.

Source files
------------

// File: rtl/dcache_arb_pkg.sv
// -----------------------------------------------------------------------------
// dcache_arb_pkg
//   Shared width helpers for the dcache response arbiter slice.
//   sel_width     : bits of source index appended to the tag (0 for 1 source)
//   idx_width     : bits needed to hold a source index (at least 1)
//   tag_out_width : merged tag width = input tag width + sel_width
// -----------------------------------------------------------------------------
package dcache_arb_pkg;

    function automatic int sel_width(input int num_inputs);
        return (num_inputs <= 1) ? 0 : $clog2(num_inputs);
    endfunction

    function automatic int idx_width(input int num_inputs);
        return (num_inputs <= 1) ? 1 : $clog2(num_inputs);
    endfunction

    function automatic int tag_out_width(input int tag_in_width, input int num_inputs);
        return tag_in_width + sel_width(num_inputs);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter owning the rotating priority pointer rr_ptr.
//   clk, reset_n   : clock, synchronous active-low reset (rr_ptr -> 0)
//   req_i          : per-source requests
//   advance_i      : strobe, a grant was consumed this cycle
//   adv_idx_i      : index of the consumed grant; pointer moves just past it
//   grant_o        : one-hot grant (first request at or after rr_ptr)
//   grant_idx_o    : binary index of the grant
//   grant_valid_o  : some request is granted
// -----------------------------------------------------------------------------
module rr_arbiter
    import dcache_arb_pkg::*;
#(
    parameter  int NUM_INPUTS = 2,
    localparam int IDX_W      = idx_width(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_INPUTS-1:0] req_i,
    input  logic                  advance_i,
    input  logic [IDX_W-1:0]      adv_idx_i,
    output logic [NUM_INPUTS-1:0] grant_o,
    output logic [IDX_W-1:0]      grant_idx_o,
    output logic                  grant_valid_o
);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             found;
    int               idx;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise paths that skip the assignment infer latches.
    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        found         = 1'b0;
        idx           = 0;
        // Scan rr_ptr, rr_ptr+1, ... with wrap; the first hit wins.
        for (int off = 0; off < NUM_INPUTS; off++) begin
            idx = int'(rr_ptr_q) + off;
            if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
            if (!found && req_i[IDX_W'(idx)]) begin
                found                  = 1'b1;
                grant_o[IDX_W'(idx)]   = 1'b1;
                grant_idx_o            = IDX_W'(idx);
                grant_valid_o          = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance_i) begin
            rr_ptr_d = (int'(adv_idx_i) == NUM_INPUTS - 1) ? '0 : adv_idx_i + 1'b1;
        end
    end

    // NOTE: clocked state is written with non-blocking assignments so every
    // register samples pre-edge values; blocking '=' stays in combinational blocks.
    always_ff @(posedge clk) begin
        if (!reset_n) rr_ptr_q <= '0;
        else          rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: rtl/dcache_rsp_arb.sv
// -----------------------------------------------------------------------------
// dcache_rsp_arb
//   Merges NUM_INPUTS dcache response streams into one channel, round-robin,
//   through a registered 2-entry elastic buffer (1 response/cycle sustained).
//   clk, reset_n : clock, synchronous active-low reset
//   in_valid     : per-source valid            in_ready  : per-source accept
//   in_tmask     : per-source lane masks       in_data   : per-source lane data
//   in_tag       : per-source tags
//   out_valid/out_tmask/out_data : merged response (head of buffer)
//   out_tag      : {in_tag[src], src}, source index in the LSBs
//   out_ready    : downstream accept
// -----------------------------------------------------------------------------
module dcache_rsp_arb
    import dcache_arb_pkg::*;
#(
    parameter  int NUM_INPUTS    = 2,
    parameter  int NUM_REQS      = 4,
    parameter  int WORD_SIZE     = 4,
    parameter  int TAG_IN_WIDTH  = 8,
    localparam int WORD_W        = 8 * WORD_SIZE,
    localparam int DATA_W        = NUM_REQS * WORD_W,
    localparam int SEL_W         = sel_width(NUM_INPUTS),
    localparam int IDX_W         = idx_width(NUM_INPUTS),
    localparam int TAG_OUT_WIDTH = tag_out_width(TAG_IN_WIDTH, NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_INPUTS-1:0]            in_valid,
    input  logic [NUM_INPUTS*NUM_REQS-1:0]   in_tmask,
    input  logic [NUM_INPUTS*DATA_W-1:0]     in_data,
    input  logic [NUM_INPUTS*TAG_IN_WIDTH-1:0] in_tag,
    output logic [NUM_INPUTS-1:0]            in_ready,
    output logic                             out_valid,
    output logic [NUM_REQS-1:0]              out_tmask,
    output logic [DATA_W-1:0]                out_data,
    output logic [TAG_OUT_WIDTH-1:0]         out_tag,
    input  logic                             out_ready
);

    // Entry layout depends on this instance's parameters, so it lives here.
    typedef struct packed {
        logic [NUM_REQS-1:0]      tmask;
        logic [DATA_W-1:0]        data;
        logic [TAG_OUT_WIDTH-1:0] tag;
    } rsp_entry_t;

    logic [NUM_INPUTS-1:0] grant_oh;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_valid;
    logic                  can_accept;
    logic                  push, pop;
    rsp_entry_t            sel_entry;

    rsp_entry_t            mem_q [2];
    logic                  head_q, tail_q;
    logic [1:0]            count_q, count_d;

    // Acceptance looks only at the registered count, never at out_ready.
    assign can_accept = (count_q != 2'd2) && reset_n;
    assign in_ready   = grant_oh & {NUM_INPUTS{can_accept}};
    assign push       = grant_valid && can_accept;
    assign pop        = out_valid && out_ready;

    rr_arbiter #(.NUM_INPUTS(NUM_INPUTS)) u_rr_arbiter (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_i         (in_valid),
        .advance_i     (push),
        .adv_idx_i     (grant_idx),
        .grant_o       (grant_oh),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    // One-hot AND-OR mux of the granted payload; source index goes into tag LSBs
    // (shift/OR by zero when there is a single source).
    always_comb begin
        sel_entry = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant_oh[i]) begin
                sel_entry.tmask = in_tmask[i*NUM_REQS +: NUM_REQS];
                sel_entry.data  = in_data[i*DATA_W +: DATA_W];
                sel_entry.tag   = (TAG_OUT_WIDTH'(in_tag[i*TAG_IN_WIDTH +: TAG_IN_WIDTH]) << SEL_W)
                                | TAG_OUT_WIDTH'(i);
            end
        end
    end

    always_comb begin
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: the two buffer entries are cleared on reset so out_* read zero
    // coming out of reset; larger storage arrays would normally be left unreset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            for (int k = 0; k < 2; k++) mem_q[k] <= '0;
        end else begin
            if (push) begin
                mem_q[tail_q] <= sel_entry;
                tail_q        <= ~tail_q;
            end
            if (pop) head_q <= ~head_q;
            count_q <= count_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_tmask = mem_q[head_q].tmask;
    assign out_data  = mem_q[head_q].data;
    assign out_tag   = mem_q[head_q].tag;

    a_ready_onehot0: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(in_ready));
    a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && count_q == 2'd2));
    a_out_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (out_valid && !out_ready) |=> $stable({out_tmask, out_data, out_tag}));

endmodule

// File: tb/tb_dcache_rsp_arb.sv
// -----------------------------------------------------------------------------
// tb_dcache_rsp_arb
//   Random and directed stimulus for dcache_rsp_arb (2 sources, 4 lanes,
//   32-bit words, 8-bit tags), checked against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_dcache_rsp_arb;

    typedef struct packed {
        logic [3:0]   tmask;
        logic [127:0] data;
        logic [8:0]   tag;
    } ent_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   in_valid;
    logic [7:0]   in_tmask;
    logic [255:0] in_data;
    logic [15:0]  in_tag;
    logic [1:0]   in_ready;
    logic         out_valid;
    logic [3:0]   out_tmask;
    logic [127:0] out_data;
    logic [8:0]   out_tag;
    logic         out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    // Source-side state: a source keeps valid and payload until accepted.
    bit           sv      [2];
    logic [3:0]   s_tmask [2];
    logic [127:0] s_data  [2];
    logic [7:0]   s_tag   [2];

    // Reference model: FIFO of expected outputs and round-robin pointer.
    ent_t         mq [$];
    int           rr = 0;
    int           dut_hs = 0;
    logic [1:0]   obs_ready;

    dcache_rsp_arb dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_tmask  (in_tmask),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_tmask (out_tmask),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // vmode: 0 random raise, 1 all sources raise, 2 only source 1 raises, 3 none raise
    // rmode: 0 out_ready=0, 1 out_ready=1, 2 random
    task automatic cycle(input int vmode, input int rmode);
        int   g;
        int   s;
        bit   raise;
        bit   popped;
        logic [1:0] exp_ready;
        ent_t e;
        for (int k = 0; k < 2; k++) begin
            if (!sv[k]) begin
                raise = (vmode == 1) || (vmode == 2 && k == 1) ||
                        (vmode == 0 && $urandom_range(0, 1) == 1);
                if (raise) begin
                    sv[k]      = 1'b1;
                    s_tmask[k] = 4'($urandom);
                    s_data[k]  = {$urandom, $urandom, $urandom, $urandom};
                    s_tag[k]   = 8'($urandom);
                end
            end
            in_valid[k]            = sv[k];
            in_tmask[k*4 +: 4]     = s_tmask[k];
            in_data[k*128 +: 128]  = s_data[k];
            in_tag[k*8 +: 8]       = s_tag[k];
        end
        out_ready = (rmode == 1) ? 1'b1 : (rmode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        #4;
        g = -1;
        for (int off = 0; off < 2; off++) begin
            s = (rr + off) % 2;
            if (g < 0 && sv[s]) g = s;
        end
        exp_ready = (reset_n && g >= 0 && mq.size() < 2) ? 2'(1 << g) : 2'b00;
        obs_ready = in_ready;
        if (|(in_ready & in_valid)) dut_hs++;
        check("in_ready", in_ready, exp_ready);
        check("out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("out_tmask", out_tmask, mq[0].tmask);
            check("out_data", out_data, mq[0].data);
            check("out_tag", out_tag, mq[0].tag);
        end
        if (!reset_n) begin
            mq.delete();
            rr = 0;
        end else begin
            popped = (mq.size() != 0) && out_ready;
            if (exp_ready != 2'b00) begin
                e.tmask = s_tmask[g];
                e.data  = s_data[g];
                e.tag   = {s_tag[g], 1'(g)};
                mq.push_back(e);
                rr    = (g + 1) % 2;
                sv[g] = 1'b0;
            end
            if (popped) void'(mq.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 10; i++) begin
            if (mq.size() == 0 && !sv[0] && !sv[1]) break;
            cycle(3, 1);
        end
        check("drain_empty", out_valid, 1'b0);
    endtask

    initial begin
        int hs0;
        logic [127:0] d_exp;
        reset_n   = 1'b0;
        in_valid  = '0;
        in_tmask  = '0;
        in_data   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with both sources valid.
        for (int i = 0; i < 3; i++) cycle(1, 1);
        check("rst_out_tag", out_tag, 9'h000);
        check("rst_out_tmask", out_tmask, 4'h0);
        check("rst_out_data", out_data, 128'h0);
        reset_n = 1'b1;
        cycle(1, 1);
        check("rst_first_grant", obs_ready, 2'b01);
        drain();

        // Single source with a known payload.
        d_exp = {$urandom, $urandom, $urandom, $urandom};
        sv[1] = 1'b1; s_tmask[1] = 4'b1011; s_tag[1] = 8'h5A; s_data[1] = d_exp;
        cycle(3, 1);
        check("single_valid", out_valid, 1'b1);
        check("single_tmask", out_tmask, 4'b1011);
        check("single_tag", out_tag, 9'h0B5);
        check("single_data", out_data, d_exp);
        drain();

        // Round-robin with continuous valid: one handshake per cycle.
        hs0 = dut_hs;
        for (int i = 0; i < 6; i++) cycle(1, 1);
        check("rr_hs_count", dut_hs - hs0, 6);
        drain();

        // Backpressure: exactly two handshakes fill the buffer.
        hs0 = dut_hs;
        for (int i = 0; i < 5; i++) cycle(1, 0);
        check("bp_hs_count", dut_hs - hs0, 2);
        check("bp_ready_low", obs_ready, 2'b00);
        drain();

        // Source 1 alone with out_ready=1: push and pop together at count 1.
        hs0 = dut_hs;
        for (int i = 0; i < 6; i++) cycle(2, 1);
        check("pushpop_hs_count", dut_hs - hs0, 6);
        drain();

        // Move the pointer to source 1, fill the buffer, then reset mid-stream.
        sv[0] = 1'b1; s_tmask[0] = 4'($urandom); s_tag[0] = 8'($urandom);
        s_data[0] = {$urandom, $urandom, $urandom, $urandom};
        cycle(3, 1);
        drain();
        for (int i = 0; i < 3; i++) cycle(1, 0);
        check("full_ready_low", obs_ready, 2'b00);
        reset_n = 1'b0;
        cycle(1, 0);
        reset_n = 1'b1;
        check("midrst_out_valid", out_valid, 1'b0);
        cycle(1, 1);
        check("midrst_first_grant", obs_ready, 2'b01);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            reset_n = ($urandom_range(0, 79) != 0);
            cycle(0, 2);
        end
        reset_n = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
